// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch FIFO between I-mem response and decode, with one-cycle flush.
// Optional combinational empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [31:0]   C_NOP  = 32'h0000_0013;

  logic [63:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic          r_fault_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_valid;
  logic          w_enq;
  logic          w_deq;
  logic [63:0]   w_head_pc;
  logic [31:0]   w_head_instr;
  logic          w_head_fault;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != C_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass     = w_empty && in_valid && !flush;
  assign w_valid      = (!w_empty || in_valid) && !flush;
  assign w_head_pc    = w_empty ? in_pc    : r_pc_mem[r_rptr];
  assign w_head_instr = w_empty ? in_instr : r_instr_mem[r_rptr];
  assign w_head_fault = w_empty ? in_fault : r_fault_mem[r_rptr];
  // A bypassed word consumed this cycle never touches storage.
  assign w_enq        = in_valid && in_ready && !flush && !(w_bypass && out_ready);
  assign w_deq        = !w_empty && w_valid && out_ready;
`else
  assign w_valid      = !w_empty && !flush;
  assign w_head_pc    = r_pc_mem[r_rptr];
  assign w_head_instr = r_instr_mem[r_rptr];
  assign w_head_fault = r_fault_mem[r_rptr];
  assign w_enq        = in_valid && in_ready && !flush;
  assign w_deq        = w_valid && out_ready;
`endif

  // Decode sees a canonical NOP whenever nothing valid is presented.
  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_head_pc    : 64'd0;
  assign out_instr = w_valid ? w_head_instr : C_NOP;
  assign out_fault = w_valid ? w_head_fault : 1'b0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wptr]    <= in_pc;
      r_instr_mem[r_wptr] <= in_instr;
      r_fault_mem[r_wptr] <= in_fault;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
